// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the 5-port mesh router (N, E, W, S, L).
//   - Default flit width and input FIFO depth.
//   - Port index constants used to order per-port signals in vectors.
//   - One-hot crossbar select encoding shared with the output arbiters.
//   - multi_hot(): true when more than one bit of a per-port vector is set.
package router_pkg;

  localparam int ROUTER_DATA_WIDTH = 32;
  localparam int ROUTER_DEPTH      = 4;

  localparam int NUM_PORTS = 5;
  localparam int PORT_N    = 0;
  localparam int PORT_E    = 1;
  localparam int PORT_W    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_L    = 4;

  typedef enum logic [NUM_PORTS-1:0] {
    XBAR_NONE = 5'b00000,
    XBAR_N    = 5'b00001,
    XBAR_E    = 5'b00010,
    XBAR_W    = 5'b00100,
    XBAR_S    = 5'b01000,
    XBAR_L    = 5'b10000
  } xbar_sel_t;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [NUM_PORTS-1:0] v);
    return |(v & (v - NUM_PORTS'(1)));
  endfunction

endpackage

// File: rtl/router_fifo_ctrl.sv
// router_fifo_ctrl
// Pointer, status and clear-to-send control for one router input FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_drts        upstream request-to-send
//   i_read_en     OR of the arbiter grants for this input
//   o_cts         registered clear-to-send pulse
//   o_wr_en       write strobe for the storage array
//   o_wr_addr     storage write index
//   o_rd_addr     storage read (head) index
//   o_empty       no valid entries
//   o_full        DEPTH valid entries
module router_fifo_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_drts,
  input  logic                     i_read_en,
  output logic                     o_cts,
  output logic                     o_wr_en,
  output logic [$clog2(DEPTH)-1:0] o_wr_addr,
  output logic [$clog2(DEPTH)-1:0] o_rd_addr,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_cts;
  logic        w_empty;
  logic        w_full;
  logic        w_wr_en;
  logic        w_rd_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Exactly one write follows each CTS pulse, and CTS is only raised when
  // not full, so a write can never land on a full FIFO.
  assign w_wr_en = r_cts & i_drts;
  assign w_rd_en = i_read_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cts    <= 1'b0;
    end else begin
      // ~r_cts forces a gap so CTS is never high on consecutive cycles.
      r_cts <= i_drts & ~r_cts & ~w_full;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  assign o_cts     = r_cts;
  assign o_wr_en   = w_wr_en;
  assign o_wr_addr = r_wr_ptr[AW-1:0];
  assign o_rd_addr = r_rd_ptr[AW-1:0];
  assign o_empty   = w_empty;
  assign o_full    = w_full;

endmodule

// File: rtl/router_input_fifo.sv
// router_input_fifo
// Per-input-port flit buffer of the mesh router. Accepts flits with the
// RTS/CTS handshake, stores them in a circular FIFO and presents the head
// flit (first-word fall-through) to routing and the crossbar.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   RX              incoming flit, DRTS upstream request-to-send
//   CTS             registered clear-to-send pulse to upstream
//   read_en_N/E/W/S/L  grants from the five output arbiters
//   Data_out        head flit (stale while empty)
//   empty, full     occupancy status
//   err             sticky protocol error (only with ROUTER_FIFO_ERR_EN)
// Build option: define ROUTER_FIFO_ERR_EN to add the err port and checker.
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int DEPTH      = ROUTER_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
`ifdef ROUTER_FIFO_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_PORTS-1:0]  w_grants;
  logic                  w_read_en;
  logic                  w_cts;
  logic                  w_wr_en;
  logic [AW-1:0]         w_wr_addr;
  logic [AW-1:0]         w_rd_addr;
  logic                  w_empty;
  logic                  w_full;

  // Storage is not reset; after reset the head simply shows whatever is in mem[0].
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign w_grants[PORT_N] = read_en_N;
  assign w_grants[PORT_E] = read_en_E;
  assign w_grants[PORT_W] = read_en_W;
  assign w_grants[PORT_S] = read_en_S;
  assign w_grants[PORT_L] = read_en_L;
  assign w_read_en        = |w_grants;

  router_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_drts    (DRTS),
    .i_read_en (w_read_en),
    .o_cts     (w_cts),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_rd_addr (w_rd_addr),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= RX;
    end
  end

  // Asynchronous head read gives fall-through: a flit is visible right after
  // the edge that wrote it.
  assign Data_out = r_mem[w_rd_addr];
  assign CTS      = w_cts;
  assign empty    = w_empty;
  assign full     = w_full;

`ifdef ROUTER_FIFO_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((w_read_en & w_empty) | multi_hot(w_grants) | (w_cts & ~DRTS)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// tb_router_input_fifo
// Directed test of router_input_fifo with hand-computed expectations.
// Covers single flit, fill to full with back-pressure, wrap-around
// streaming, simultaneous read/write, reset mid-transfer and (when built
// with ROUTER_FIFO_ERR_EN) the sticky error flag.
module tb_router_input_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] RX = '0;
  logic        DRTS = 1'b0;
  logic        CTS;
  logic        read_en_N = 1'b0;
  logic        read_en_E = 1'b0;
  logic        read_en_W = 1'b0;
  logic        read_en_S = 1'b0;
  logic        read_en_L = 1'b0;
  logic [31:0] Data_out;
  logic        empty;
  logic        full;
`ifdef ROUTER_FIFO_ERR_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  router_input_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .DRTS      (DRTS),
    .CTS       (CTS),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full)
`ifdef ROUTER_FIFO_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream model: raise DRTS, wait (bounded) for CTS, hold through the write edge, drop.
  task automatic send_flit(input logic [31:0] v);
    bit got = 0;
    DRTS = 1'b1;
    RX   = v;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (CTS) got = 1;
    end
    if (got) tick();
    DRTS = 1'b0;
    chk("send_cts_seen", 32'(got), 32'd1);
    $display("send flit 0x%0h", v);
  endtask

  // Check the head flit, then pop it through the N grant.
  task automatic pop(input logic [31:0] exp);
    chk("pop_head", Data_out, exp);
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
    $display("pop flit 0x%0h", exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  idx;
    bit  saw_full;

    // ---------------- reset ----------------
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_cts", 32'(CTS), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
    chk("reset_err", 32'(err), 32'd0);
`endif

    // ---------------- single flit ----------------
    DRTS = 1'b1;
    RX   = 32'hDEADBEEF;
    tick();
    chk("single_cts_pulse", 32'(CTS), 32'd1);
    chk("single_empty_before_write", 32'(empty), 32'd1);
    tick();
    DRTS = 1'b0;
    chk("single_cts_drop", 32'(CTS), 32'd0);
    chk("single_empty_after_write", 32'(empty), 32'd0);
    chk("single_data", Data_out, 32'hDEADBEEF);
    read_en_L = 1'b1;
    tick();
    read_en_L = 1'b0;
    chk("single_empty_after_read", 32'(empty), 32'd1);
    $display("single flit done");

    // ---------------- fill to full ----------------
    for (int i = 1; i <= 4; i++) send_flit(32'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_head", Data_out, 32'h1);
    DRTS = 1'b1;
    RX   = 32'h5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("fill_cts_blocked", 32'(CTS), 32'd0);
    end
    read_en_N = 1'b1;
    tick();
    read_en_N = 1'b0;
    chk("fill_full_after_read", 32'(full), 32'd0);
    chk("fill_head_after_read", Data_out, 32'h2);
    chk("fill_cts_not_yet", 32'(CTS), 32'd0);
    tick();
    chk("fill_cts_issued", 32'(CTS), 32'd1);
    tick();
    DRTS = 1'b0;
    chk("fill_full_again", 32'(full), 32'd1);
    pop(32'h2);
    pop(32'h3);
    pop(32'h4);
    pop(32'h5);
    chk("fill_drained", 32'(empty), 32'd1);

    // ---------------- wrap-around streaming ----------------
    idx      = 0;
    saw_full = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_flit(32'h10 + 32'(i));
      end
      begin
        for (int c = 0; c < 200 && idx < 10; c++) begin
          tick();
          if (full) saw_full = 1;
          if (!empty) begin
            chk("wrap_data", Data_out, 32'h10 + 32'(idx));
            idx++;
            read_en_E = 1'b1;
          end else begin
            read_en_E = 1'b0;
          end
        end
        tick();
        read_en_E = 1'b0;
      end
    join
    chk("wrap_count", 32'(idx), 32'd10);
    chk("wrap_never_full", 32'(saw_full), 32'd0);
    chk("wrap_empty", 32'(empty), 32'd1);

    // ---------------- simultaneous read/write at occupancy 3 ----------------
    send_flit(32'h30);
    send_flit(32'h31);
    send_flit(32'h32);
    DRTS = 1'b1;
    RX   = 32'h33;
    tick();
    chk("rw_cts", 32'(CTS), 32'd1);
    read_en_W = 1'b1;
    tick();
    read_en_W = 1'b0;
    DRTS      = 1'b0;
    chk("rw_head", Data_out, 32'h31);
    chk("rw_not_full", 32'(full), 32'd0);
    chk("rw_not_empty", 32'(empty), 32'd0);
    pop(32'h31);
    pop(32'h32);
    pop(32'h33);
    chk("rw_empty_after_three", 32'(empty), 32'd1);

    // ---------------- reset mid-operation ----------------
    send_flit(32'h40);
    send_flit(32'h41);
    DRTS = 1'b1;
    RX   = 32'h42;
    tick();
    chk("rst_mid_cts_high", 32'(CTS), 32'd1);
    rst  = 1'b1;
    DRTS = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_cts", 32'(CTS), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_full", 32'(full), 32'd0);
    send_flit(32'hAA);
    chk("rst_mid_first", Data_out, 32'hAA);
    pop(32'hAA);
    chk("rst_mid_empty_after", 32'(empty), 32'd1);

`ifdef ROUTER_FIFO_ERR_EN
    // ---------------- error flag ----------------
    chk("err_clean_traffic", 32'(err), 32'd0);
    read_en_S = 1'b1;
    tick();
    read_en_S = 1'b0;
    chk("err_read_empty", 32'(err), 32'd1);
    tick();
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    send_flit(32'h50);
    chk("err_after_send", 32'(err), 32'd0);
    read_en_N = 1'b1;
    read_en_W = 1'b1;
    tick();
    read_en_N = 1'b0;
    read_en_W = 1'b0;
    chk("err_multi_grant", 32'(err), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
